// File: rtl/fir_pkg.sv
// Shared types and helpers for the time-multiplexed FIR filter.
package fir_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StOut
  } fir_state_e;

  // Ceiling log2, never less than 1 so that address ports are always at least one bit wide.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned v;
    int unsigned r;
    v = (n > 0) ? n - 1 : 0;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  // Smallest accumulator that cannot overflow when summing n_taps full-precision products.
  function automatic int unsigned acc_width_min(input int unsigned data_w,
                                                input int unsigned coef_w,
                                                input int unsigned n_taps);
    return data_w + coef_w + clog2(n_taps);
  endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Round-half-up arithmetic shift followed by saturation to the output width.
// Purely combinational; the parent registers the result.
module fir_round_sat
  import fir_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = 37,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned SHIFT     = 15
) (
  input  logic [ACC_WIDTH-1:0] i_acc,
  output logic [OUT_WIDTH-1:0] o_data,
  output logic                 o_sat
);

  // One guard bit so the rounding add cannot wrap.
  localparam int unsigned EXT_W = ACC_WIDTH + 1;

  logic signed [EXT_W-1:0]      w_ext;
  logic signed [EXT_W-1:0]      w_r;
  logic        [EXT_W-OUT_WIDTH:0] w_hi;

  assign w_ext = {i_acc[ACC_WIDTH-1], i_acc};

  if (SHIFT > 0) begin : g_round
    localparam logic signed [EXT_W-1:0] HALF = EXT_W'(1) << (SHIFT - 1);
    logic signed [EXT_W-1:0] w_rnd;
    assign w_rnd = w_ext + HALF;
    assign w_r   = w_rnd >>> SHIFT;
  end else begin : g_no_round
    assign w_r = w_ext;
  end

  // The value fits iff every bit from the output sign bit upward is a copy of the sign.
  assign w_hi = w_r[EXT_W-1:OUT_WIDTH-1];

  // Clip to the signed output range and flag when clipping happened.
  always_comb begin
    o_sat  = !((&w_hi) || !(|w_hi));
    o_data = w_r[OUT_WIDTH-1:0];
    if (o_sat) begin
      o_data = w_r[EXT_W-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/fir_tdm_mac.sv
// Time-multiplexed direct-form FIR: one multiplier, one tap per clock, runtime-loadable
// coefficients, valid/ready on both sides, rounded and saturated output.
module fir_tdm_mac
  import fir_pkg::*;
#(
  parameter int unsigned N_TAPS     = 21,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned COEF_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 37,
  parameter int unsigned OUT_WIDTH  = 16,
  parameter int unsigned SHIFT      = 15,
  localparam int unsigned ADDR_W    = clog2(N_TAPS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [OUT_WIDTH-1:0]  m_data,
  output logic                  m_sat,
  input  logic                  coef_we,
  input  logic [ADDR_W-1:0]     coef_addr,
  input  logic [COEF_WIDTH-1:0] coef_wdata,
  output logic                  busy
);

  localparam int unsigned       PROD_W   = DATA_WIDTH + COEF_WIDTH;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_TAPS - 1);

  if (ACC_WIDTH < acc_width_min(DATA_WIDTH, COEF_WIDTH, N_TAPS)) begin : g_acc_width_check
    $error("fir_tdm_mac: ACC_WIDTH too small for DATA_WIDTH+COEF_WIDTH+clog2(N_TAPS)");
  end

  fir_state_e r_state, w_state_d;

  logic signed [DATA_WIDTH-1:0] r_x [N_TAPS];
  logic signed [COEF_WIDTH-1:0] r_h [N_TAPS];
  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic signed [ACC_WIDTH-1:0]  w_acc_next;
  logic signed [PROD_W-1:0]     w_prod;
  logic        [ADDR_W-1:0]     r_idx;
  logic                         r_m_valid;
  logic                         r_m_sat;
  logic        [OUT_WIDTH-1:0]  r_m_data;
  logic        [OUT_WIDTH-1:0]  w_rs_data;
  logic                         w_rs_sat;
  logic                         w_accept;
  logic                         w_coef_ok;
  logic                         w_last_mac;

  assign w_accept   = (r_state == StIdle) && s_valid;
  assign w_coef_ok  = (r_state == StIdle) && coef_we && (32'(coef_addr) < N_TAPS);
  assign w_last_mac = (r_state == StMac) && (r_idx == LAST_IDX);
  assign w_prod     = PROD_W'(r_x[r_idx]) * PROD_W'(r_h[r_idx]);
  assign w_acc_next = r_acc + ACC_WIDTH'(w_prod);

  // Round the final sum combinationally so the output registers load on the last MAC edge.
  fir_round_sat #(
    .ACC_WIDTH(ACC_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .SHIFT    (SHIFT)
  ) u_round_sat (
    .i_acc (w_acc_next),
    .o_data(w_rs_data),
    .o_sat (w_rs_sat)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  // FSM next state: accept, then N_TAPS MAC cycles, then hold the output until taken.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (s_valid) w_state_d = StMac;
      StMac:   if (r_idx == LAST_IDX) w_state_d = StOut;
      StOut:   if (m_ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Delay line: shift in the newest sample at x[0] on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_TAPS; k++) r_x[k] <= '0;
    end else if (w_accept) begin
      r_x[0] <= s_data;
      for (int k = 1; k < N_TAPS; k++) r_x[k] <= r_x[k-1];
    end
  end

  // Coefficient bank: writes only land while idle and in range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_TAPS; k++) r_h[k] <= '0;
    end else if (w_coef_ok) begin
      r_h[coef_addr] <= coef_wdata;
    end
  end

  // Accumulator and tap index; the index parks on the last tap so it never leaves the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_idx <= '0;
    end else if (w_accept) begin
      r_acc <= '0;
      r_idx <= '0;
    end else if (r_state == StMac) begin
      r_acc <= w_acc_next;
      if (r_idx != LAST_IDX) r_idx <= r_idx + ADDR_W'(1);
    end
  end

  // Output register: load on the last MAC edge, hold under backpressure, drop on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_sat   <= 1'b0;
    end else if (w_last_mac) begin
      r_m_valid <= 1'b1;
      r_m_data  <= w_rs_data;
      r_m_sat   <= w_rs_sat;
    end else if ((r_state == StOut) && m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign s_ready = (r_state == StIdle);
  assign busy    = (r_state != StIdle);
  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign m_sat   = r_m_sat;

endmodule
